// File: rtl/scan_mux_seq.sv
// ---------------------------------------------------------------------------
// scan_mux_seq
//   Registered N:1 channel multiplexer with two operating modes:
//     MANUAL - the channel is chosen by sel.
//     SCAN   - round-robin over the enabled channels, DWELL cycles each.
//   Every output is registered, so there is one cycle of latency from the
//   inputs to out.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   in         in   NUM_CH*DW  flattened channel data, channel k = in[k*DW +: DW]
//   sel        in   SELW       MANUAL select, or start hint on SCAN entry
//   mode       in   1          0 = MANUAL, 1 = SCAN
//   ch_en      in   NUM_CH     per-channel enable mask
//   out        out  DW         selected data (registered)
//   out_ch     out  SELW       channel id that produced out
//   out_valid  out  1          out comes from an enabled, in-range channel
//   wrap       out  1          one-cycle pulse when the scan moves to a
//                              channel id <= the previous one
// ---------------------------------------------------------------------------
module scan_mux_seq #(
  parameter int NUM_CH = 16,
  parameter int DW     = 1,
  parameter int SELW   = 4,
  parameter int DWELL  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*DW-1:0] in,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic [NUM_CH-1:0]    ch_en,
  output logic [DW-1:0]        out,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  output logic                 wrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {ST_MANUAL, ST_SCAN} state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   dwell_q, dwell_d;
  // Set while SCAN has no enabled channel; the next non-empty mask re-enters.
  logic            hold_q, hold_d;
  logic [DW-1:0]   out_q, out_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic            out_valid_q, out_valid_d;
  logic            wrap_q, wrap_d;

  // Unflattened channel data.
  logic [DW-1:0] ch_data [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in[gi*DW +: DW];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Channel search: entry pointer, next pointer after ptr_q, enable at ptr_q.
  // Loops count downward so the last hit is the lowest matching index.
  // -------------------------------------------------------------------------
  logic [SELW-1:0] lowest_ptr;
  logic [SELW-1:0] entry_ptr;
  logic            entry_found;
  logic [SELW-1:0] next_ptr;
  logic            next_found;
  logic            ptr_en;

  always_comb begin
    lowest_ptr  = '0;
    entry_ptr   = '0;
    entry_found = 1'b0;
    next_ptr    = '0;
    next_found  = 1'b0;
    ptr_en      = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        lowest_ptr = SELW'(i);
        if (SELW'(i) >= sel) begin
          entry_ptr   = SELW'(i);
          entry_found = 1'b1;
        end
        if (SELW'(i) > ptr_q) begin
          next_ptr   = SELW'(i);
          next_found = 1'b1;
        end
      end
      if (SELW'(i) == ptr_q) begin
        ptr_en = ch_en[i];
      end
    end
    if (!entry_found) begin
      entry_ptr = lowest_ptr;
    end
    // Nothing above ptr_q: wrap round to the lowest enabled channel.
    if (!next_found) begin
      next_ptr = lowest_ptr;
    end
  end

  // -------------------------------------------------------------------------
  // Decide the scan pointer for this edge.
  // -------------------------------------------------------------------------
  logic any_en;
  logic entering;
  logic advance;
  logic [SELW-1:0] scan_ptr;

  always_comb begin
    any_en   = |ch_en;
    entering = (state_q == ST_MANUAL) || hold_q;
    advance  = 1'b0;
    scan_ptr = ptr_q;
    if (entering) begin
      scan_ptr = entry_ptr;
    end else if ((dwell_q == CW'(DWELL - 1)) || !ptr_en) begin
      // Dwell expired, or the current channel was disabled mid-dwell.
      advance  = 1'b1;
      scan_ptr = next_ptr;
    end
  end

  // -------------------------------------------------------------------------
  // Data / enable lookup at the channel that will be presented. An index
  // beyond NUM_CH matches nothing and therefore yields zero / disabled.
  // -------------------------------------------------------------------------
  logic [SELW-1:0] look_idx;
  logic [DW-1:0]   look_data;
  logic            look_en;

  always_comb begin
    look_idx  = mode ? scan_ptr : sel;
    look_data = '0;
    look_en   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SELW'(i) == look_idx) begin
        look_data = ch_data[i];
        look_en   = ch_en[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = mode ? ST_SCAN : ST_MANUAL;
    ptr_d       = ptr_q;
    dwell_d     = dwell_q;
    hold_d      = 1'b0;
    out_d       = '0;
    out_ch_d    = ptr_q;
    out_valid_d = 1'b0;
    wrap_d      = 1'b0;

    if (!mode) begin
      ptr_d    = '0;
      dwell_d  = '0;
      out_ch_d = sel;
      if (look_en) begin
        out_d       = look_data;
        out_valid_d = 1'b1;
      end
    end else if (!any_en) begin
      hold_d  = 1'b1;
      dwell_d = '0;
    end else begin
      ptr_d       = scan_ptr;
      out_ch_d    = scan_ptr;
      out_d       = look_data;
      out_valid_d = 1'b1;
      if (entering || advance) begin
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q + CW'(1);
      end
      wrap_d = advance && (scan_ptr <= ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_MANUAL;
      ptr_q       <= '0;
      dwell_q     <= '0;
      hold_q      <= 1'b0;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dwell_q     <= dwell_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule
